// File: rtl/load_store_unit_pkg.sv
// Shared funct3 codes, FSM state codes and decode helpers for the load/store unit.
package load_store_unit_pkg;

    // RV32I load funct3 codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // RV32I store funct3 codes
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // FSM state codes
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_SECOND = 1'b1;

    // Request saved across the two halves of a split access
    typedef struct packed {
        logic        is_st;
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [1:0]  rem;    // bytes still to move in the second cycle (1..3)
        logic [31:0] data;
    } split_req_t;

    // Access size in bytes; invalid codes decode as 4 but are rejected by the fault logic
    function automatic logic [2:0] f3_size(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: f3_size = 3'd1;
            3'b001, 3'b101: f3_size = 3'd2;
            default:        f3_size = 3'd4;
        endcase
    endfunction

    function automatic logic [3:0] size_mask(input logic [2:0] size);
        case (size)
            3'd1:    size_mask = 4'b0001;
            3'd2:    size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic ld_f3_ok(input logic [2:0] f3);
        ld_f3_ok = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                   (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    function automatic logic st_f3_ok(input logic [2:0] f3);
        st_f3_ok = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Byte-lane steering: store enables/data placement and load extract/extend.
// Works on a 64-bit window {hi word, lo word} so split accesses need no special case.
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [2:0]  func_3,
    input  logic [31:0] st_data,
    input  logic [31:0] rd_lo,
    input  logic [31:0] rd_hi,
    output logic [3:0]  be_lo,
    output logic [31:0] wdata_lo,
    output logic [31:0] wdata_hi,
    output logic [31:0] ld_ext
);

    logic [4:0]  shamt;
    logic [63:0] wfull;
    logic [31:0] rword;

    // Shift store data/mask up by the byte offset and shift the load window down
    always_comb begin
        shamt    = {off, 3'b000};
        be_lo    = size_mask(f3_size(func_3)) << off;
        wfull    = {32'h0, st_data} << shamt;
        wdata_lo = wfull[31:0];
        wdata_hi = wfull[63:32];
        rword    = 32'({rd_hi, rd_lo} >> shamt);
        case (func_3)
            F3_LB:   ld_ext = {{24{rword[7]}}, rword[7:0]};
            F3_LBU:  ld_ext = {24'h0, rword[7:0]};
            F3_LH:   ld_ext = {{16{rword[15]}}, rword[15:0]};
            F3_LHU:  ld_ext = {16'h0, rword[15:0]};
            default: ld_ext = rword;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: byte-addressed RV32I loads/stores onto a word memory,
// splitting word-straddling accesses into two cycles and rejecting bad requests.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_WORDS  = 152
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ld_req,
    input  logic                  st_req,
    input  logic [2:0]            func_3,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           st_data,
    output logic [31:0]           ld_data,
    output logic                  ld_valid,
    output logic                  stall,
    output logic                  fault,
    output logic [ADDR_WIDTH-3:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_be,
    output logic                  mem_we,
    input  logic [31:0]           mem_rdata
);

    localparam int WW = ADDR_WIDTH - 2;
    // One extra bit so widx+1 never wraps before the range check
    localparam logic [WW:0] MEM_LIMIT = (WW+1)'(MEM_WORDS);

    logic [0:0]    state_q, state_d;
    logic [WW-1:0] nxt_q, nxt_d;
    logic [31:0]   hold_q, hold_d;
    split_req_t    req_q, req_d;

    logic [1:0]    off;
    logic [WW-1:0] widx;
    logic [WW:0]   widx_p1;
    logic [2:0]    end_pos;
    logic          split;
    logic          any_req;
    logic          fault_c;
    logic          in_second;

    logic [1:0]    al_off;
    logic [2:0]    al_f3;
    logic [31:0]   al_data, al_rd_lo, al_rd_hi;
    logic [3:0]    al_be_lo;
    logic [31:0]   al_wdata_lo, al_wdata_hi, al_ld_ext;
    logic [3:0]    rem_be;

    // Request decode and rejection checks for the IDLE cycle
    always_comb begin
        off       = addr[1:0];
        widx      = addr[ADDR_WIDTH-1:2];
        widx_p1   = {1'b0, widx} + 1'b1;
        end_pos   = {1'b0, off} + f3_size(func_3);
        split     = end_pos > 3'd4;
        any_req   = ld_req | st_req;
        in_second = (state_q == ST_SECOND);
        fault_c   = (ld_req && st_req) ||
                    (ld_req && !ld_f3_ok(func_3)) ||
                    (st_req && !st_f3_ok(func_3)) ||
                    ({1'b0, widx} >= MEM_LIMIT) ||
                    (split && (widx_p1 >= MEM_LIMIT));
    end

    // Lane aligner sees the live request in IDLE and the saved one in SECOND
    always_comb begin
        al_off   = in_second ? req_q.off  : off;
        al_f3    = in_second ? req_q.f3   : func_3;
        al_data  = in_second ? req_q.data : st_data;
        al_rd_lo = in_second ? hold_q     : mem_rdata;
        al_rd_hi = in_second ? mem_rdata  : 32'h0;
        case (req_q.rem)
            2'd1:    rem_be = 4'b0001;
            2'd2:    rem_be = 4'b0011;
            2'd3:    rem_be = 4'b0111;
            default: rem_be = 4'b0000;
        endcase
    end

    lsu_lane_align u_align (
        .off      (al_off),
        .func_3   (al_f3),
        .st_data  (al_data),
        .rd_lo    (al_rd_lo),
        .rd_hi    (al_rd_hi),
        .be_lo    (al_be_lo),
        .wdata_lo (al_wdata_lo),
        .wdata_hi (al_wdata_hi),
        .ld_ext   (al_ld_ext)
    );

    // FSM next state, memory drive and core-facing responses
    always_comb begin
        state_d   = state_q;
        nxt_d     = nxt_q;
        hold_d    = hold_q;
        req_d     = req_q;
        ld_data   = 32'h0;
        ld_valid  = 1'b0;
        stall     = 1'b0;
        fault     = 1'b0;
        mem_addr  = widx;
        mem_wdata = 32'h0;
        mem_be    = 4'b0000;
        mem_we    = 1'b0;

        if (in_second) begin
            // Second half: request inputs are ignored, saved copy drives everything
            mem_addr = nxt_q;
            if (req_q.is_st) begin
                mem_we    = 1'b1;
                mem_be    = rem_be;
                mem_wdata = al_wdata_hi;
            end else begin
                ld_valid = 1'b1;
                ld_data  = al_ld_ext;
            end
            state_d = ST_IDLE;
        end else if (any_req) begin
            if (fault_c) begin
                fault    = 1'b1;
                ld_valid = ld_req;
            end else begin
                if (st_req) begin
                    mem_we    = 1'b1;
                    mem_be    = al_be_lo;
                    mem_wdata = al_wdata_lo;
                end
                if (split) begin
                    stall        = 1'b1;
                    // Whole word is kept; lanes below off fall out of the shift later
                    hold_d       = mem_rdata;
                    nxt_d        = widx_p1[WW-1:0];
                    req_d.is_st  = st_req;
                    req_d.f3     = func_3;
                    req_d.off    = off;
                    req_d.rem    = end_pos[1:0];
                    req_d.data   = st_data;
                    state_d      = ST_SECOND;
                end else if (ld_req) begin
                    ld_valid = 1'b1;
                    ld_data  = al_ld_ext;
                end
            end
        end

        // Reset silences every side effect, including a pending second half
        if (reset) begin
            ld_data   = 32'h0;
            ld_valid  = 1'b0;
            stall     = 1'b0;
            fault     = 1'b0;
            mem_we    = 1'b0;
            mem_be    = 4'b0000;
            mem_wdata = 32'h0;
        end
    end

    // State, saved request and hold register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            nxt_q   <= '0;
            hold_q  <= 32'h0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            nxt_q   <= nxt_d;
            hold_q  <= hold_d;
            req_q   <= req_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word-memory model.
module tb_load_store_unit;

    localparam int AW = 32;
    localparam int MW = 152;

    logic          clk = 1'b0;
    logic          reset;
    logic          ld_req, st_req;
    logic [2:0]    func_3;
    logic [AW-1:0] addr;
    logic [31:0]   st_data;
    logic [31:0]   ld_data;
    logic          ld_valid, stall, fault;
    logic [AW-3:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_be;
    logic          mem_we;
    logic [31:0]   mem_rdata;

    logic [31:0]   mem [MW];
    logic          mem_clr;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_WIDTH(AW), .MEM_WORDS(MW)) dut (
        .clk       (clk),
        .reset     (reset),
        .ld_req    (ld_req),
        .st_req    (st_req),
        .func_3    (func_3),
        .addr      (addr),
        .st_data   (st_data),
        .ld_data   (ld_data),
        .ld_valid  (ld_valid),
        .stall     (stall),
        .fault     (fault),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    always_comb begin
        mem_rdata = 32'h0;
        if (mem_addr < AW'(MW)) mem_rdata = mem[mem_addr[7:0]];
    end

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < MW; i++) mem[i] <= 32'h0;
        end else if (mem_we && mem_addr < AW'(MW)) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) mem[mem_addr[7:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic l, input logic s, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] d);
        ld_req = l; st_req = s; func_3 = f; addr = a; st_data = d;
        #1;
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; mem_clr = 1'b1;
        drv(1'b1, 1'b0, 3'b010, 32'h0, 32'h0);
        nxt(); nxt();
        #1;
        chk("rst_stall",  {31'h0, stall},    32'h0);
        chk("rst_valid",  {31'h0, ld_valid}, 32'h0);
        chk("rst_fault",  {31'h0, fault},    32'h0);
        chk("rst_we",     {31'h0, mem_we},   32'h0);
        chk("rst_be",     {28'h0, mem_be},   32'h0);
        chk("rst_ldata",  ld_data,           32'h0);
        reset = 1'b0; mem_clr = 1'b0;
        drv(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        chk("idle_we",    {31'h0, mem_we},   32'h0);
        chk("idle_valid", {31'h0, ld_valid}, 32'h0);
        nxt();

        // Aligned SW
        drv(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        chk("sw_addr",  32'(mem_addr), 32'd4);
        chk("sw_be",    {28'h0, mem_be}, 32'hF);
        chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
        chk("sw_we",    {31'h0, mem_we}, 32'h1);
        chk("sw_stall", {31'h0, stall}, 32'h0);
        nxt();

        // SB into top lane, then byte/half loads of the merged word 0xA5ADBEEF
        drv(1'b0, 1'b1, 3'b000, 32'h13, 32'h000000A5);
        chk("sb_be",    {28'h0, mem_be}, 32'h8);
        chk("sb_wdata", mem_wdata, 32'hA5000000);
        nxt();
        drv(1'b1, 1'b0, 3'b000, 32'h13, 32'h0);
        chk("lb_data",  ld_data, 32'hFFFFFFA5);
        chk("lb_valid", {31'h0, ld_valid}, 32'h1);
        chk("lb_we",    {31'h0, mem_we}, 32'h0);
        nxt();
        drv(1'b1, 1'b0, 3'b100, 32'h13, 32'h0);
        chk("lbu_data", ld_data, 32'h000000A5);
        nxt();
        drv(1'b1, 1'b0, 3'b001, 32'h12, 32'h0);
        chk("lh_data",  ld_data, 32'hFFFFA5AD);
        nxt();
        drv(1'b1, 1'b0, 3'b101, 32'h12, 32'h0);
        chk("lhu_data", ld_data, 32'h0000A5AD);
        nxt();

        // Preload words 3 and 4, then misaligned LW at 0x0E
        drv(1'b0, 1'b1, 3'b010, 32'h0C, 32'h44332211); nxt();
        drv(1'b0, 1'b1, 3'b010, 32'h10, 32'h88776655); nxt();
        drv(1'b1, 1'b0, 3'b010, 32'h0E, 32'h0);
        chk("mlw0_stall", {31'h0, stall}, 32'h1);
        chk("mlw0_addr",  32'(mem_addr), 32'd3);
        chk("mlw0_valid", {31'h0, ld_valid}, 32'h0);
        nxt();
        drv(1'b1, 1'b0, 3'b000, 32'h0, 32'h0);   // live inputs must be ignored
        chk("mlw1_addr",  32'(mem_addr), 32'd4);
        chk("mlw1_valid", {31'h0, ld_valid}, 32'h1);
        chk("mlw1_data",  ld_data, 32'h66554433);
        chk("mlw1_stall", {31'h0, stall}, 32'h0);
        nxt();

        // Misaligned SH at 0x07
        drv(1'b0, 1'b1, 3'b001, 32'h07, 32'h0000BBAA);
        chk("msh0_addr",  32'(mem_addr), 32'd1);
        chk("msh0_be",    {28'h0, mem_be}, 32'h8);
        chk("msh0_wdata", mem_wdata, 32'hAA000000);
        chk("msh0_stall", {31'h0, stall}, 32'h1);
        nxt();
        chk("msh1_addr",  32'(mem_addr), 32'd2);
        chk("msh1_be",    {28'h0, mem_be}, 32'h1);
        chk("msh1_wdata", mem_wdata, 32'h000000BB);
        chk("msh1_we",    {31'h0, mem_we}, 32'h1);
        nxt();
        drv(1'b1, 1'b0, 3'b010, 32'h04, 32'h0);
        chk("msh_word1", ld_data, 32'hAA000000);
        nxt();
        drv(1'b1, 1'b0, 3'b010, 32'h08, 32'h0);
        chk("msh_word2", ld_data, 32'h000000BB);
        nxt();

        // Range and funct3 faults
        drv(1'b1, 1'b0, 3'b010, 32'h260, 32'h0);
        chk("f_oor_fault", {31'h0, fault}, 32'h1);
        chk("f_oor_data",  ld_data, 32'h0);
        chk("f_oor_valid", {31'h0, ld_valid}, 32'h1);
        chk("f_oor_we",    {31'h0, mem_we}, 32'h0);
        nxt();
        drv(1'b1, 1'b0, 3'b010, 32'h25E, 32'h0);
        chk("f_split_fault", {31'h0, fault}, 32'h1);
        chk("f_split_stall", {31'h0, stall}, 32'h0);
        nxt();
        drv(1'b1, 1'b0, 3'b010, 32'h25C, 32'h0);
        chk("last_word_fault", {31'h0, fault}, 32'h0);
        nxt();
        drv(1'b1, 1'b0, 3'b011, 32'h0, 32'h0);
        chk("f_f3_fault", {31'h0, fault}, 32'h1);
        nxt();
        drv(1'b0, 1'b1, 3'b100, 32'h0, 32'h12345678);
        chk("f_stf3_fault", {31'h0, fault}, 32'h1);
        chk("f_stf3_we",    {31'h0, mem_we}, 32'h0);
        nxt();
        drv(1'b1, 1'b1, 3'b010, 32'h0, 32'h0);
        chk("f_both_fault", {31'h0, fault}, 32'h1);
        nxt();
        drv(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        chk("f_pulse", {31'h0, fault}, 32'h0);
        nxt();

        // Reset during the second half of a split SW at 0x22
        drv(1'b0, 1'b1, 3'b010, 32'h22, 32'h11223344);
        chk("rs0_stall", {31'h0, stall}, 32'h1);
        chk("rs0_be",    {28'h0, mem_be}, 32'hC);
        nxt();
        reset = 1'b1;
        #1;
        chk("rs1_we",    {31'h0, mem_we}, 32'h0);
        chk("rs1_stall", {31'h0, stall}, 32'h0);
        nxt();
        reset = 1'b0;
        drv(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        chk("rs2_stall", {31'h0, stall}, 32'h0);
        chk("rs2_we",    {31'h0, mem_we}, 32'h0);
        nxt();
        drv(1'b1, 1'b0, 3'b010, 32'h24, 32'h0);
        chk("rs_word9",  ld_data, 32'h0);
        chk("rs_idle",   {31'h0, stall}, 32'h0);
        nxt();
        drv(1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
        chk("rs_word8",  ld_data, 32'h33440000);
        nxt();

        drv(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
